// File: rtl/fsm_pkg.sv
// Shared state encodings for the w conditioner and the downstream sequence-detector benches.
package fsm_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b11,
    PEND_LO   = 2'b10
  } state_e;

  localparam int unsigned DEBOUNCE_DEFAULT = 3;

  // Debounced level implied by a state: high while stable high or while a fall is pending.
  function automatic logic level_of(input state_e s);
    return (s == STABLE_HI) || (s == PEND_LO);
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/w_conditioner.sv
// Synchronizes and debounces the raw w line; emits a clean level plus edge and glitch strobes.
module w_conditioner
  import fsm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic w_raw,
  output logic w,
  output logic w_rise,
  output logic w_fall,
  output logic glitch
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             DIRECT   = (DEBOUNCE_CYCLES == 1);

  logic             w_sync;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             w_q;
  logic             rise_q;
  logic             fall_q;
  logic             glitch_q;

  sync2 #(.W(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (w_raw),
    .q_o   (w_sync)
  );

  // Qualification FSM; the stable-level check has priority so the completing sample can still reject.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      w_q      <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
      case (state_q)
        STABLE_LO: begin
          if (w_sync) begin
            if (DIRECT) begin
              state_q <= STABLE_HI;
              cnt_q   <= '0;
              w_q     <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              state_q <= PEND_HI;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        PEND_HI: begin
          if (!w_sync) begin
            state_q  <= STABLE_LO;
            cnt_q    <= '0;
            glitch_q <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            w_q     <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!w_sync) begin
            if (DIRECT) begin
              state_q <= STABLE_LO;
              cnt_q   <= '0;
              w_q     <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              state_q <= PEND_LO;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        PEND_LO: begin
          if (w_sync) begin
            state_q  <= STABLE_HI;
            cnt_q    <= '0;
            glitch_q <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            w_q     <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= STABLE_LO;
          cnt_q   <= '0;
          w_q     <= 1'b0;
        end
      endcase
    end
  end

  assign w      = w_q;
  assign w_rise = rise_q;
  assign w_fall = fall_q;
  assign glitch = glitch_q;

endmodule
